// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared state encoding and sizing for the register write arbiter
package reg_arb_pkg;

  localparam int NREQ_MAX  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int PTR_W     = $clog2(NREQ_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first set req at or after ptr, wrapping
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

  logic found;

  // First pass covers indices at/after ptr; the second pass wraps to the lowest set index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        winner[j] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        winner[j] = 1'b1;
        found     = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter loading a shared holding register with 4-phase ack
// Optional REG_WRITE_ARBITER_PRIO0_EN: requester 0 wins outright and does not advance the pointer.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  ld_en,
  output logic [WIDTH-1:0]      ld_data,
  output logic                  busy
);

  state_t           state, state_nx;
  logic [PTR_W-1:0] ptr, ptr_nx, ptr_adv;
  logic [NREQ-1:0]  grant_nx, ack_nx, rr_win, pick;
  logic [WIDTH-1:0] ld_data_nx, pick_data;
  logic             rr_valid, pick_prio, win_prio, win_prio_nx;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (rr_win),
    .valid  (rr_valid)
  );

`ifdef REG_WRITE_ARBITER_PRIO0_EN
  always_comb begin
    pick_prio = req[0];
    pick      = req[0] ? {{(NREQ-1){1'b0}}, 1'b1} : rr_win;
  end
`else
  always_comb begin
    pick_prio = 1'b0;
    pick      = rr_win;
  end
`endif

  always_comb begin
    pick_data = '0;
    ptr_adv   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_data = din[i*WIDTH +: WIDTH];
      if (grant[i]) ptr_adv = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    ack_nx      = ack;
    ld_data_nx  = ld_data;
    ptr_nx      = ptr;
    win_prio_nx = win_prio;
    case (state)
      ST_IDLE: begin
        if (rr_valid) begin
          state_nx    = ST_LOAD;
          grant_nx    = pick;
          ld_data_nx  = pick_data;
          win_prio_nx = pick_prio;
        end
      end
      ST_LOAD: begin
        state_nx = ST_ACK;
        ack_nx   = grant;
      end
      ST_ACK: begin
        // Hold until the winner drops its request, closing the 4-phase handshake.
        if ((req & grant) == '0) begin
          state_nx = ST_IDLE;
          ack_nx   = '0;
          grant_nx = '0;
          if (!win_prio) ptr_nx = ptr_adv;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      ack      <= '0;
      ld_data  <= '0;
      ptr      <= '0;
      win_prio <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      ack      <= ack_nx;
      ld_data  <= ld_data_nx;
      ptr      <= ptr_nx;
      win_prio <= win_prio_nx;
    end
  end

  assign ld_en = (state == ST_LOAD);
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter (NREQ=2, WIDTH=8)
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] din;
  logic [1:0]  grant, ack;
  logic        ld_en, busy;
  logic [7:0]  ld_data;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.NREQ(2), .WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .grant   (grant),
    .ack     (ack),
    .ld_en   (ld_en),
    .ld_data (ld_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int         exp_ptr;
  int         w;
  logic [7:0] exp_data;

  initial begin
    rst = 1'b1;
    req = 2'b11;
    din = 16'h5A5A;
    @(negedge clk);

    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_ld_en", 32'(ld_en), 32'h0);
      chk("rst_ld_data", 32'(ld_data), 32'h00);
      chk("rst_busy", 32'(busy), 32'h0);
    end

    // Single request from requester 1
    rst = 1'b0;
    req = 2'b10;
    din = {8'hA5, 8'h00};
    chk("single_pre_ld_en", 32'(ld_en), 32'h0);
    tick();
    chk("single_ld_en", 32'(ld_en), 32'h1);
    chk("single_ld_data", 32'(ld_data), 32'hA5);
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_ack_early", 32'(ack), 32'h0);
    tick();
    chk("single_ld_en_once", 32'(ld_en), 32'h0);
    chk("single_ack", 32'(ack), 32'h2);
    tick();
    chk("single_ack_hold", 32'(ack), 32'h2);
    chk("single_busy_hold", 32'(busy), 32'h1);
    req = 2'b00;
    tick();
    chk("single_ack_drop", 32'(ack), 32'h0);
    chk("single_grant_drop", 32'(grant), 32'h0);
    chk("single_busy_drop", 32'(busy), 32'h0);

    // Simultaneous requests, winner drops and re-raises each round
    exp_ptr = 0;
    din = {8'h22, 8'h11};
    for (int r = 0; r < 4; r++) begin
      req = 2'b11;
`ifdef REG_WRITE_ARBITER_PRIO0_EN
      w = 0;
`else
      w = exp_ptr;
`endif
      exp_data = (w == 0) ? 8'h11 : 8'h22;
      tick();
      chk("sim_ld_en", 32'(ld_en), 32'h1);
      chk("sim_ld_data", 32'(ld_data), 32'(exp_data));
      tick();
      chk("sim_ack", 32'(ack), 32'(2'b01 << w));
      req = (w == 0) ? 2'b10 : 2'b01;
      tick();
      chk("sim_idle", 32'(busy), 32'h0);
`ifndef REG_WRITE_ARBITER_PRIO0_EN
      exp_ptr = (w + 1) % 2;
`endif
    end
    req = 2'b00;
    tick();

    // Data freeze: din changes during LOAD are ignored
    req = 2'b01;
    din = {8'h00, 8'h3C};
    tick();
    chk("frz_ld_data", 32'(ld_data), 32'h3C);
    din = {8'h00, 8'hFF};
    tick();
    chk("frz_ld_data_ack", 32'(ld_data), 32'h3C);
    chk("frz_ack", 32'(ack), 32'h1);
    req = 2'b00;
    tick();
    chk("frz_ld_data_hold", 32'(ld_data), 32'h3C);

    // Reset during LOAD; pointer must return to 0
    req = 2'b10;
    din = {8'h77, 8'h66};
    tick();
    chk("mid_ld_en", 32'(ld_en), 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_ld_en", 32'(ld_en), 32'h0);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    req = 2'b11;
    tick();
    chk("mid_ptr0_grant", 32'(grant), 32'h1);
    chk("mid_ptr0_data", 32'(ld_data), 32'h66);
    chk("mid_no_ack", 32'(ack), 32'h0);
    req = 2'b00;
    tick();
    chk("mid_ack", 32'(ack), 32'h1);
    tick();
    chk("mid_idle", 32'(busy), 32'h0);

    // Early drop during LOAD still completes the load with a one-cycle ack
    req = 2'b01;
    din = {8'h00, 8'h9E};
    tick();
    chk("early_ld_en", 32'(ld_en), 32'h1);
    chk("early_ld_data", 32'(ld_data), 32'h9E);
    req = 2'b00;
    tick();
    chk("early_ack", 32'(ack), 32'h1);
    chk("early_ld_en_off", 32'(ld_en), 32'h0);
    tick();
    chk("early_ack_off", 32'(ack), 32'h0);
    chk("early_idle", 32'(busy), 32'h0);
    chk("early_grant_off", 32'(grant), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
